// File: rtl/sm_run_ctrl.sv
// Run/halt/step/breakpoint controller driving the schoolRISCV core enable.
// Optional watchdog on free-run length: define SM_RUN_CTRL_WATCHDOG_EN.
module sm_run_ctrl #(
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 32,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic [CNT_W-1:0] step_count,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] remaining_s;
  logic [CNT_W-1:0] step_load_s;
  logic             skip_r;
  logic             skip_s;
  logic             halted_r;
  logic             bp_hit_r;
  logic [CYC_W-1:0] cycle_cnt_r;
  logic             bp_match_s;
  logic             cpu_en_s;
  logic             wdog_expire_s;

  // skip masks the breakpoint for the single instruction retired on resume
  assign bp_match_s  = bp_valid & (pc == bp_addr) & ~skip_r;
  assign cpu_en_s    = ((state_r == ST_RUN) | (state_r == ST_STEP)) & ~bp_match_s;
  assign step_load_s = (step_count == {CNT_W{1'b0}}) ? CNT_W'(1) : step_count;

`ifdef SM_RUN_CTRL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              timeout_r;

  assign wdog_expire_s = (state_r == ST_RUN) & cpu_en_s &
                         (wdog_cnt_r == WDOG_W'(WDOG_LIMIT - 1));
  assign timeout       = timeout_r;

  // RUN-length counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      if ((state_s == ST_RUN) && (state_r != ST_RUN)) begin
        wdog_cnt_r <= {WDOG_W{1'b0}};
      end else if ((state_r == ST_RUN) && cpu_en_s) begin
        wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
      end else begin
        wdog_cnt_r <= wdog_cnt_r;
      end
      if (wdog_expire_s) begin
        timeout_r <= 1'b1;
      end else if (cmd_run | cmd_step) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end
`else
  // without the watchdog, timeout is a constant 0
  localparam logic WDOG_TIE = 1'b0 & (WDOG_LIMIT > 0);

  assign wdog_expire_s = 1'b0;
  assign timeout       = WDOG_TIE;
`endif

  // next-state and remaining-steps logic; command priority halt > step > run
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    if (cpu_en_s) begin
      skip_s = 1'b0;
    end else begin
      skip_s = skip_r;
    end
    case (state_r)
      ST_HALT, ST_BREAK: begin
        if (cmd_halt) begin
          state_s = ST_HALT;
        end else if (cmd_step) begin
          state_s     = ST_STEP;
          remaining_s = step_load_s;
          skip_s      = (state_r == ST_BREAK);
        end else if (cmd_run) begin
          state_s = ST_RUN;
          skip_s  = (state_r == ST_BREAK);
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (cmd_halt | wdog_expire_s) begin
          state_s = ST_HALT;
        end else if (bp_match_s) begin
          state_s = ST_BREAK;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STEP: begin
        if (cmd_halt) begin
          state_s     = ST_HALT;
          remaining_s = {CNT_W{1'b0}};
        end else if (cmd_run) begin
          state_s     = ST_RUN;
          remaining_s = {CNT_W{1'b0}};
        end else if (bp_match_s) begin
          state_s     = ST_BREAK;
          remaining_s = {CNT_W{1'b0}};
        end else if (cpu_en_s) begin
          if (remaining_r == CNT_W'(1)) begin
            state_s     = ST_HALT;
            remaining_s = {CNT_W{1'b0}};
          end else begin
            state_s     = ST_STEP;
            remaining_s = remaining_r - CNT_W'(1);
          end
        end else begin
          state_s = ST_STEP;
        end
      end
      default: begin
        state_s     = ST_HALT;
        remaining_s = {CNT_W{1'b0}};
        skip_s      = 1'b0;
      end
    endcase
  end

  // state, status flags and retired-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_HALT;
      remaining_r <= {CNT_W{1'b0}};
      skip_r      <= 1'b0;
      halted_r    <= 1'b1;
      bp_hit_r    <= 1'b0;
      cycle_cnt_r <= {CYC_W{1'b0}};
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      skip_r      <= skip_s;
      halted_r    <= (state_s == ST_HALT) | (state_s == ST_BREAK);
      bp_hit_r    <= (state_s == ST_BREAK);
      if (cpu_en_s) begin
        cycle_cnt_r <= cycle_cnt_r + CYC_W'(1);
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
    end
  end

  assign cpu_en    = cpu_en_s;
  assign state     = state_r;
  assign halted    = halted_r;
  assign bp_hit    = bp_hit_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl: behavioural model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_sm_run_ctrl;

  localparam int TB_WDOG = 20;
  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_BREAK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_run = 1'b0;
  logic        cmd_halt = 1'b0;
  logic        cmd_step = 1'b0;
  logic [7:0]  step_count = 8'd0;
  logic [31:0] pc;
  logic [31:0] bp_addr = 32'h0;
  logic        bp_valid = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic        bp_hit;
  logic        timeout;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  sm_run_ctrl #(.CNT_W(8), .CYC_W(32), .WDOG_LIMIT(TB_WDOG)) dut (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .cmd_step(cmd_step), .step_count(step_count), .pc(pc),
    .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en),
    .state(state), .halted(halted), .bp_hit(bp_hit),
    .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // toy core: a 8-instruction loop 0x00..0x1C that advances on every enable
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else if (cpu_en) pc <= (pc + 32'd4) & 32'h1F;
  end

  typedef struct packed {
    int          mode;
    int          left;
    bit          skip;
    logic [31:0] cycles;
    bit          tout;
    int          wd;
  } model_t;

  model_t m;

  function automatic bit m_en(model_t c);
    return ((c.mode == M_RUN) || (c.mode == M_STEP)) &&
           !(bp_valid && (pc == bp_addr) && !c.skip);
  endfunction

  function automatic model_t model_next(model_t c);
    model_t n = c;
    bit bpm = bp_valid && (pc == bp_addr) && !c.skip;
    bit en = m_en(c);
    bit wd_fire = 1'b0;
    if (en) begin
      n.cycles = c.cycles + 32'd1;
      n.skip = 1'b0;
    end
`ifdef SM_RUN_CTRL_WATCHDOG_EN
    if ((c.mode == M_RUN) && en) begin
      n.wd = c.wd + 1;
      wd_fire = (n.wd == TB_WDOG);
    end
    if (cmd_run || cmd_step) n.tout = 1'b0;
    if (wd_fire) n.tout = 1'b1;
`endif
    case (c.mode)
      M_HALT, M_BREAK: begin
        if (cmd_halt) n.mode = M_HALT;
        else if (cmd_step) begin
          n.mode = M_STEP;
          n.left = (step_count == 8'd0) ? 1 : int'(step_count);
          n.skip = (c.mode == M_BREAK);
        end else if (cmd_run) begin
          n.mode = M_RUN;
          n.skip = (c.mode == M_BREAK);
        end
      end
      M_RUN: begin
        if (cmd_halt || wd_fire) n.mode = M_HALT;
        else if (bpm) n.mode = M_BREAK;
      end
      M_STEP: begin
        if (cmd_halt) n.mode = M_HALT;
        else if (cmd_run) n.mode = M_RUN;
        else if (bpm) n.mode = M_BREAK;
        else if (en) begin
          n.left = c.left - 1;
          if (n.left == 0) n.mode = M_HALT;
        end
      end
      default: n.mode = M_HALT;
    endcase
    if ((n.mode == M_RUN) && (c.mode != M_RUN)) n.wd = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{mode: M_HALT, left: 0, skip: 1'b0, cycles: 32'h0, tout: 1'b0, wd: 0};
    else m <= model_next(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("m_cpu_en", 32'(cpu_en), 32'(m_en(m)));
        check("m_state", 32'(state), 32'(m.mode));
        check("m_halted", 32'(halted), 32'((m.mode == M_HALT) || (m.mode == M_BREAK)));
        check("m_bp_hit", 32'(bp_hit), 32'(m.mode == M_BREAK));
        check("m_timeout", 32'(timeout), 32'(m.tout));
        check("m_cycle_cnt", cycle_cnt, m.cycles);
      end
    end
  end

  task automatic pulse(input bit r, input bit h, input bit s, input logic [7:0] n);
    @(posedge clk); #1;
    cmd_run = r; cmd_halt = h; cmd_step = s; step_count = n;
    @(posedge clk); #1;
    cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic count_en(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (cpu_en) c++;
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string name);
    int k = 0;
    while ((state !== s) && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    repeat (10) @(negedge clk);
    check("idle_state", 32'(state), 32'd0);
    check("idle_cpu_en", 32'(cpu_en), 32'd0);
    check("idle_halted", 32'(halted), 32'd1);
    check("idle_cycle_cnt", cycle_cnt, 32'd0);

    // three-instruction step
    pulse(1'b0, 1'b0, 1'b1, 8'd3);
    count_en(8, c);
    check("step3_enabled", 32'(c), 32'd3);
    check("step3_state", 32'(state), 32'd0);
    check("step3_cycle_cnt", cycle_cnt, 32'd3);

    // free run into a breakpoint at 0x10
    do_reset();
    bp_addr = 32'h10; bp_valid = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 8'd0);
    wait_state(2'd3, 20, "bp_reach_state");
    check("bp_pc", pc, 32'h10);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_cpu_en", 32'(cpu_en), 32'd0);
    check("bp_cycle_cnt", cycle_cnt, 32'd4);

    // resume: 0x10 retires once, loop comes back round and breaks again
    pulse(1'b1, 1'b0, 1'b0, 8'd0);
    check("resume_state", 32'(state), 32'd1);
    wait_state(2'd3, 40, "bp_again_state");
    check("bp_again_pc", pc, 32'h10);
    check("bp_again_cycle_cnt", cycle_cnt, 32'd12);

    // halt beats step when both arrive in RUN
    @(posedge clk); #1 bp_valid = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    pulse(1'b0, 1'b1, 1'b1, 8'd4);
    count_en(4, c);
    check("halt_step_enabled", 32'(c), 32'd0);
    check("halt_step_state", 32'(state), 32'd0);

    // step_count of zero behaves as one
    pulse(1'b0, 1'b0, 1'b1, 8'd0);
    count_en(6, c);
    check("step0_enabled", 32'(c), 32'd1);
    check("step0_state", 32'(state), 32'd0);

    // async reset in the middle of a 5-step
    do_reset();
    pulse(1'b0, 1'b0, 1'b1, 8'd5);
    check("midstep_cpu_en", 32'(cpu_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

`ifdef SM_RUN_CTRL_WATCHDOG_EN
    // watchdog stops an unbounded run after TB_WDOG enabled cycles
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 8'd0);
    begin
      int k = 0;
      c = 0;
      while ((state !== 2'd0) && (k < 60)) begin
        @(negedge clk);
        if (cpu_en) c++;
        k++;
      end
    end
    check("wd_enabled", 32'(c), 32'd20);
    check("wd_state", 32'(state), 32'd0);
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_cycle_cnt", cycle_cnt, 32'd20);
    pulse(1'b0, 1'b0, 1'b1, 8'd1);
    check("wd_timeout_clr", 32'(timeout), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/sm_run_ctrl.md
Name: sm_run_ctrl

Overview:
- Execution controller for the schoolRISCV core; generates the per-cycle CPU enable that gates instruction retirement in sm_top.
- Supports halt, free run, N-instruction single-step and one hardware PC breakpoint.
- Sits between the board/debug command inputs and the core's clock-enable input.
- Exposes the state and a retired-cycle counter for the debug display.

Parameters:
- CNT_W, 8, width of the step-count input and the internal remaining-steps counter.
- CYC_W, 32, width of the cycle_cnt output.
- WDOG_LIMIT, 1000, RUN-cycle limit; used only when SM_RUN_CTRL_WATCHDOG_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_run  in  1  single-cycle pulse: enter RUN.
- cmd_halt  in  1  single-cycle pulse: enter HALT.
- cmd_step  in  1  single-cycle pulse: execute step_count instructions.
- step_count  in  CNT_W  number of instructions per step command; sampled with cmd_step.
- pc  in  32  core's current PC, i.e. the instruction retired if cpu_en=1 this cycle.
- bp_addr  in  32  breakpoint address.
- bp_valid  in  1  breakpoint armed.
- cpu_en  out  1  core enable; the instruction at pc retires on a clk edge with cpu_en=1.
- state  out  2  HALT=0, RUN=1, STEP=2, BREAK=3.
- halted  out  1  1 when state is HALT or BREAK.
- bp_hit  out  1  1 while state is BREAK.
- timeout  out  1  watchdog expiry flag.
- cycle_cnt  out  CYC_W  count of enabled cycles.

Behaviour:
- Reset (async, any time, including mid-STEP or mid-RUN):
  - state=HALT, cpu_en=0, halted=1, bp_hit=0, timeout=0, cycle_cnt=0.
  - Remaining-steps counter=0, skip flag=0.
- Registered state machine with a combinational cpu_en:
  - bp_match = bp_valid & (pc==bp_addr) & ~skip.
  - cpu_en = (state==RUN | state==STEP) & ~bp_match.
- Command priority when pulses coincide: halt > step > run.
- HALT:
  - cmd_run -> RUN.
  - cmd_step -> STEP, remaining=step_count; step_count==0 is treated as 1.
  - cmd_halt: no effect.
- RUN:
  - cmd_halt -> HALT. The instruction at pc in that cycle still retires if cpu_en=1.
  - bp_match -> BREAK; the instruction at bp_addr does not retire.
  - cmd_run and cmd_step: ignored.
- STEP:
  - Each cycle with cpu_en=1 decrements remaining.
  - An enabled cycle with remaining==1 -> HALT.
  - bp_match -> BREAK, and remaining is discarded.
  - cmd_halt -> HALT.
  - cmd_run -> RUN.
  - cmd_step: ignored.
- BREAK:
  - cmd_run -> RUN with skip=1.
  - cmd_step -> STEP with skip=1, remaining loaded as in HALT.
  - cmd_halt -> HALT, which clears bp_hit.
- Skip flag:
  - Set only on leaving BREAK.
  - Cleared after the first cycle with cpu_en=1, so the breakpoint instruction retires exactly once on resume.
  - A second pass through bp_addr breaks again.
- Changing bp_addr or bp_valid while RUN takes effect on the same cycle's compare (combinational).
- cycle_cnt:
  - +1 on every clk edge with cpu_en=1.
  - Wraps modulo 2^CYC_W with no flag.
- Outputs state, halted and bp_hit are registered. Only cpu_en is combinational.
- Latency: a command pulse at edge N gives the new state and cpu_en after edge N (first enabled cycle is N+1).

Optional Feature:
- Macro: SM_RUN_CTRL_WATCHDOG_EN.
- Defined:
  - An internal counter clears on entry to RUN and increments on each RUN cycle with cpu_en=1.
  - On reaching WDOG_LIMIT -> HALT and timeout=1.
  - timeout stays 1 until the next cmd_run or cmd_step, or reset.
- Not defined: no counter; timeout is tied to 0.

Test Plan:
- Reset then idle 10 cycles -> state=0, cpu_en=0, halted=1, cycle_cnt=0.
- From HALT, cmd_step with step_count=3 -> cpu_en high exactly 3 cycles, state back to 0, cycle_cnt=3.
- cmd_run with bp_valid=1, bp_addr=0x10, pc advancing by 4 from 0 -> cpu_en drops when pc=0x10, state=3, bp_hit=1, cycle_cnt=4.
- From BREAK, cmd_run -> the instruction at 0x10 retires once, RUN continues; the next pass of pc=0x10 breaks again.
- Simultaneous cmd_halt and cmd_step in RUN -> state=0, no step loaded; step_count=0 from HALT -> exactly 1 enabled cycle.
- Assert rst mid-STEP (remaining=5) -> cpu_en=0 immediately and all outputs at reset values. With SM_RUN_CTRL_WATCHDOG_EN and WDOG_LIMIT=20, cmd_run with no breakpoint -> HALT after 20 enabled cycles, timeout=1.
